// File: rtl/alu_adder_unit.sv
// Registered ALU plus PC-increment and branch-target adders.
// Every output is a flop; en gates capture and valid mirrors en.
module alu_adder_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic              overflow,
  output logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] pc_branch,
  output logic              valid
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11
  } alu_op_e;

  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;
  logic [DATA_W-1:0] result;
  logic              ovf;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] next_plus4;
  logic [DATA_W-1:0] next_branch;

  assign add_res     = src_a + src_b;
  assign sub_res     = src_a - src_b;
  assign shamt       = src_b[4:0];
  assign next_plus4  = pc + DATA_W'(4);
  assign next_branch = next_plus4 + (imm << 2);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_op)
      OP_ADD: begin
        result = add_res;
        ovf    = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                 (add_res[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_SUB: begin
        result = sub_res;
        ovf    = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                 (sub_res[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_AND:  result = src_a & src_b;
      OP_OR:   result = src_a | src_b;
      OP_XOR:  result = src_a ^ src_b;
      OP_NOR:  result = ~(src_a | src_b);
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, src_a < src_b};
      OP_SLL:  result = src_a << shamt;
      OP_SRL:  result = src_a >> shamt;
      OP_SRA:  result = DATA_W'($signed(src_a) >>> shamt);
      OP_LUI:  result = {src_b[15:0], 16'h0000};
      default: result = '0;
    endcase
  end

  // zero is derived from the same result word that lands in alu_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out   <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      pc_plus4  <= '0;
      pc_branch <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        alu_out   <= result;
        zero      <= (result == '0);
        overflow  <= ovf;
        pc_plus4  <= next_plus4;
        pc_branch <= next_branch;
      end
    end
  end

endmodule

// File: tb/tb_alu_adder_unit.sv
// Self-checking bench for alu_adder_unit: directed table, hold/reset
// sequences and randomized traffic against an arithmetic reference model.
module tb_alu_adder_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  alu_op;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        zero;
  logic        overflow;
  logic [31:0] pc_plus4;
  logic [31:0] pc_branch;
  logic        valid;

  int pass_count = 0;
  int check_count = 0;

  typedef struct {
    logic [31:0] out;
    logic        zero;
    logic        ovf;
    logic [31:0] p4;
    logic [31:0] br;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    exp_t        exp;
  } vec_t;

  vec_t vecs[16];
  exp_t held;
  exp_t reset_exp;

  alu_adder_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .src_a     (src_a),
    .src_b     (src_b),
    .alu_op    (alu_op),
    .pc        (pc),
    .imm       (imm),
    .alu_out   (alu_out),
    .zero      (zero),
    .overflow  (overflow),
    .pc_plus4  (pc_plus4),
    .pc_branch (pc_branch),
    .valid     (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: signed arithmetic on wide integers, not bit tricks.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] p,
                                 input logic [31:0] im);
    exp_t   e;
    int     sa;
    int     sb;
    longint wide;
    int     sh;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    e.ovf = 1'b0;
    case (op)
      4'd0: begin
        wide  = longint'(sa) + longint'(sb);
        e.out = wide[31:0];
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd1: begin
        wide  = longint'(sa) - longint'(sb);
        e.out = wide[31:0];
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd2:  e.out = a & b;
      4'd3:  e.out = a | b;
      4'd4:  e.out = a ^ b;
      4'd5:  e.out = ~(a | b);
      4'd6:  e.out = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  e.out = (a < b) ? 32'd1 : 32'd0;
      4'd8:  e.out = a << sh;
      4'd9:  e.out = a >> sh;
      4'd10: e.out = a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd11: e.out = b * 32'd65536;
      default: e.out = 32'd0;
    endcase
    e.zero = (e.out == 32'd0);
    e.p4   = p + 32'd4;
    e.br   = p + 32'd4 + im * 32'd4;
    return e;
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] p,
                               input logic [31:0] im, input logic e);
    @(negedge clk);
    alu_op = op;
    src_a  = a;
    src_b  = b;
    pc     = p;
    imm    = im;
    en     = e;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    check_count++;
    if (act === req) pass_count++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic checkAll(input string name, input exp_t e, input logic v);
    checkOutput({name, ".alu_out"},   alu_out,          e.out);
    checkOutput({name, ".zero"},      {31'd0, zero},     {31'd0, e.zero});
    checkOutput({name, ".overflow"},  {31'd0, overflow}, {31'd0, e.ovf});
    checkOutput({name, ".pc_plus4"},  pc_plus4,         e.p4);
    checkOutput({name, ".pc_branch"}, pc_branch,        e.br);
    checkOutput({name, ".valid"},     {31'd0, valid},    {31'd0, v});
  endtask

  initial begin
    reset_exp = '{out: 32'd0, zero: 1'b1, ovf: 1'b0, p4: 32'd0, br: 32'd0};

    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h1, 32'h00400000, 32'hFFFFFFFF,
                 '{32'h80000000, 1'b0, 1'b1, 32'h00400004, 32'h00400000}};
    vecs[1]  = '{4'd1,  32'd5, 32'd5, 32'hFFFFFFFC, 32'h0,
                 '{32'h0, 1'b1, 1'b0, 32'h0, 32'h0}};
    vecs[2]  = '{4'd6,  32'hFFFFFFFF, 32'h1, 32'h00001000, 32'h40000001,
                 '{32'h1, 1'b0, 1'b0, 32'h00001004, 32'h00001008}};
    vecs[3]  = '{4'd7,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h1,
                 '{32'h0, 1'b1, 1'b0, 32'h4, 32'h8}};
    vecs[4]  = '{4'd10, 32'h80000000, 32'd4, 32'h0, 32'h0,
                 '{32'hF8000000, 1'b0, 1'b0, 32'h4, 32'h4}};
    vecs[5]  = '{4'd9,  32'h80000000, 32'd4, 32'h0, 32'h0,
                 '{32'h08000000, 1'b0, 1'b0, 32'h4, 32'h4}};
    vecs[6]  = '{4'd11, 32'hDEADBEEF, 32'h1234, 32'h0, 32'h0,
                 '{32'h12340000, 1'b0, 1'b0, 32'h4, 32'h4}};
    vecs[7]  = '{4'd1,  32'h80000000, 32'h1, 32'h0, 32'h0,
                 '{32'h7FFFFFFF, 1'b0, 1'b1, 32'h4, 32'h4}};
    vecs[8]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0,
                 '{32'hF000F000, 1'b0, 1'b0, 32'h4, 32'h4}};
    vecs[9]  = '{4'd5,  32'h0, 32'h0, 32'h0, 32'h0,
                 '{32'hFFFFFFFF, 1'b0, 1'b0, 32'h4, 32'h4}};
    vecs[10] = '{4'd13, 32'h1234, 32'h5678, 32'h0, 32'h0,
                 '{32'h0, 1'b1, 1'b0, 32'h4, 32'h4}};
    vecs[11] = '{4'd8,  32'h1, 32'h1F, 32'h0, 32'h0,
                 '{32'h80000000, 1'b0, 1'b0, 32'h4, 32'h4}};
    vecs[12] = '{4'd8,  32'hABCD, 32'h20, 32'h0, 32'h0,
                 '{32'hABCD, 1'b0, 1'b0, 32'h4, 32'h4}};
    vecs[13] = '{4'd0,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
                 '{32'h0, 1'b1, 1'b0, 32'h4, 32'h4}};
    vecs[14] = '{4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h10, 32'hFFFFFFFE,
                 '{32'h55555555, 1'b0, 1'b0, 32'h14, 32'h0000000C}};
    vecs[15] = '{4'd3,  32'h00F0, 32'h0F00, 32'h0, 32'h0,
                 '{32'h0FF0, 1'b0, 1'b0, 32'h4, 32'h4}};

    rst_n = 1'b0;
    en = 1'b1;
    alu_op = 4'd0;
    src_a = 32'd3;
    src_b = 32'd4;
    pc = 32'h100;
    imm = 32'h1;

    // Reset held across edges with en=1 must keep everything at reset values.
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset_hold", reset_exp, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm, 1'b1);
      checkAll($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
    end

    // Three idle cycles with churning inputs: data holds, valid drops.
    held = vecs[15].exp;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'(i), 32'h11111111 * (i + 1), 32'h3, 32'h2000 + i, 32'h5, 1'b0);
      checkAll($sformatf("hold%0d", i), held, 1'b0);
    end

    // Asynchronous reset between edges after a valid capture.
    applyStimulus(4'd0, 32'd3, 32'd4, 32'h100, 32'h1, 1'b1);
    checkAll("pre_reset", '{32'd7, 1'b0, 1'b0, 32'h104, 32'h108}, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", reset_exp, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    held = reset_exp;

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic [31:0] im;
      logic        e;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h7FFFFFFF;
      if ($urandom_range(0, 7) == 0) b = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = a;
      p  = $urandom & 32'hFFFFFFFC;
      im = $urandom;
      e  = ($urandom_range(0, 3) != 0);
      applyStimulus(op, a, b, p, im, e);
      if (e) held = model(op, a, b, p, im);
      checkAll($sformatf("rand%0d", i), held, e);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu_adder_unit.md
ALU_ADDER_UNIT -- requirements
Module: alu_adder_unit

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is required to be supported.
REQ-002 Port: clk  input  1  rising-edge clock for all registers.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  capture enable; outputs update only on a clk edge with en=1.
REQ-005 Port: src_a  input  32  ALU operand A.
REQ-006 Port: src_b  input  32  ALU operand B; src_b[4:0] is the shift amount.
REQ-007 Port: alu_op  input  4  operation select.
REQ-008 Port: pc  input  32  current program counter.
REQ-009 Port: imm  input  32  sign-extended branch immediate, in words.
REQ-010 Port: alu_out  output  32  registered ALU result.
REQ-011 Port: zero  output  1  registered flag, 1 when the captured ALU result is 0.
REQ-012 Port: overflow  output  1  registered signed-overflow flag for ADD/SUB.
REQ-013 Port: pc_plus4  output  32  registered pc+4.
REQ-014 Port: pc_branch  output  32  registered branch target.
REQ-015 Port: valid  output  1  registered copy of en.

Function
REQ-016 alu_op encoding:
- 0 ADD
- 1 SUB (a-b)
- 2 AND
- 3 OR
- 4 XOR
- 5 NOR
- 6 SLT (signed a<b -> 1, else 0)
- 7 SLTU (unsigned a<b -> 1, else 0)
- 8 SLL (a << b[4:0])
- 9 SRL (logical a >> b[4:0])
- 10 SRA (arithmetic a >>> b[4:0])
- 11 LUI ({b[15:0],16'h0})
- 12-15 result 0
REQ-017 ADD/SUB/pc_plus4/pc_branch arithmetic is modulo 2^32; carries out of bit 31 are discarded.
REQ-018 overflow: ADD sets it when a and b have the same sign and the result sign differs; SUB sets it when a and b have different signs and the result sign differs from a; 0 for all other ops. Results still wrap.
REQ-019 pc_plus4 = pc + 32'd4; pc = 32'hFFFFFFFC wraps to 0.
REQ-020 pc_branch = (pc + 4) + (imm << 2); the shifted-out imm bits [31:30] are discarded.
REQ-021 SLT compares as two's complement; SLTU compares as unsigned; a shift amount of 0 returns a unchanged.
REQ-022 Latency is exactly 1 cycle: inputs sampled at edge N with en=1 appear on all outputs after edge N.
REQ-023 en=0 at an edge: alu_out, zero, overflow, pc_plus4 and pc_branch hold their values; valid goes to 0.
REQ-024 There is no combinational path from any input to any output.
REQ-025 zero is computed from the same result that is captured into alu_out on that edge.

Reset
REQ-026 rst_n=0 immediately, without waiting for clk, forces alu_out=0, zero=1, overflow=0, pc_plus4=0, pc_branch=0, valid=0.
REQ-027 Outputs stay at reset values while rst_n=0 regardless of en.
REQ-028 The first capture occurs at the first rising edge with rst_n=1 and en=1.
REQ-029 Reset asserted mid-operation discards the pending capture, and outputs go to reset values at once.

Verification
REQ-030 ADD a=0x7FFFFFFF, b=1, en=1 -> next cycle alu_out=0x80000000, overflow=1, zero=0, valid=1.
REQ-031 SUB a=5, b=5 -> alu_out=0, zero=1, overflow=0; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-032 SRA a=0x80000000, b=4 -> 0xF8000000; SRL with the same operands -> 0x08000000; LUI b=0x1234 -> 0x12340000.
REQ-033 pc=0x00400000, imm=0xFFFFFFFF -> pc_plus4=0x00400004, pc_branch=0x00400000; pc=0xFFFFFFFC -> pc_plus4=0.
REQ-034 en=0 for 3 cycles with changing inputs -> data outputs hold their last values, valid=0.
REQ-035 Drop rst_n between clk edges after a valid capture -> all outputs reach reset values before the next edge.
